uart_buffered_core: RTL and testbench

// Parametrised full-duplex UART: own TX and RX bit engines, configurable frame format
// (5-9 data bits, none/odd/even parity, 1 or 2 stop bits), valid/ready host ports and
// an RX FIFO with sticky error flags. Successor to the fixed 8N1 unbuffered rx->tx

---
 rtl/uart_buffered_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_buffered_core.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_core.sv
// rtl/uart_buffered_core.sv - full-duplex UART with configurable frame format and RX FIFO
// TX/RX bit engines share one baud divider value; RX feeds a FWFT FIFO with sticky error flags.
module uart_buffered_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int DATAWIDTH  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATAWIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATAWIDTH-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [AW:0]          rx_count,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);
  localparam int BAUD_DIV = CLK_FREQ / BAUDRATE;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    DW_LAST  = 4'(DATAWIDTH - 1);
  localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic          ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATAWIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                 tx_par_q, tx_par_d, rx_par_q, rx_par_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic                 push_q, push_d;
  logic [DATAWIDTH-1:0] push_data_q, push_data_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          count_q, count_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATAWIDTH-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                 tx_tick, rx_sample, frame_ev, parity_ev, pop, push_ok;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    txd        = 1'b1;
    tx_tick    = (tx_cnt_q == BIT_END);
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CNT_ONE;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_sh_d    = tx_data;
          tx_par_d   = ODD;
          tx_bit_d   = '0;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (tx_tick) tx_state_d = S_DATA;
      end
      S_DATA: begin
        txd = tx_sh_q[0];
        if (tx_tick) begin
          tx_par_d = tx_par_q ^ tx_sh_q[0];
          tx_sh_d  = {1'b0, tx_sh_q[DATAWIDTH-1:1]};
          if (tx_bit_q == DW_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        txd = tx_par_q;
        if (tx_tick) tx_state_d = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) begin
          if (tx_bit_q == SB_LAST) tx_state_d = S_IDLE;
          else tx_bit_d = tx_bit_q + 4'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign tx_ready = (tx_state_q == S_IDLE);

  // The start sample lands half a bit in; every later sample is one full bit after the previous one.
  always_comb begin
    rx_s1_d     = rxd;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_par_d    = rx_par_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_ev    = 1'b0;
    parity_ev   = 1'b0;
    rx_sample   = (rx_state_q == S_START) ? (rx_cnt_q == HALF) : (rx_cnt_q == BIT_END);
    rx_cnt_d    = rx_sample ? '0 : rx_cnt_q + CNT_ONE;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_sample) begin
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          rx_bit_d   = '0;
          rx_par_d   = 1'b0;
        end
      end
      S_DATA: begin
        if (rx_sample) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATAWIDTH-1:1]};
          rx_par_d = rx_par_q ^ rx_s2_q;
          if (rx_bit_q == DW_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_par_q ^ rx_s2_q;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_sample) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q) begin
            frame_ev = 1'b1;
          end else if ((PARITY != 0) && (rx_par_q != ODD)) begin
            parity_ev = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = rx_sh_q;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = rx_valid_q && rx_ready;
    push_ok = push_q && ((count_q != OCC_FULL) || pop);
    wr_d    = push_ok ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    count_d = count_q;
    if (push_ok && !pop) count_d = count_q + OCC_ONE;
    if (!push_ok && pop) count_d = count_q - OCC_ONE;
    rx_valid_d = (count_d != '0);
    rx_data_d  = rx_data_q;
    // A push into an otherwise-empty FIFO must bypass the memory to reach the head register.
    if (count_d != '0) begin
      if (push_ok && (count_q == (pop ? OCC_ONE : '0))) rx_data_d = push_data_q;
      else rx_data_d = mem_q[rd_d];
    end
    ferr_d = frame_ev | (ferr_q & ~err_clr);
    perr_d = parity_ev | (perr_q & ~err_clr);
    oerr_d = (push_q & ~push_ok) | (oerr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_par_q    <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_par_q    <= tx_par_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_par_q    <= rx_par_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      oerr_q      <= oerr_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_count    = count_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
endmodule

// File: tb/tb_uart_buffered_core.sv
// tb/tb_uart_buffered_core.sv - directed/random bench for uart_buffered_core
// Instance a: 8N1, instance b: 8E1, instance c: 9O2 looped back txd->rxd; BAUD_DIV = 10.
module tb_uart_buffered_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       a_rxd = 1'b1, a_txd, a_tx_valid = 1'b0, a_tx_ready, a_rx_valid, a_rx_ready = 1'b0;
  logic [7:0] a_tx_data = '0, a_rx_data;
  logic [4:0] a_rx_count;
  logic       a_perr, a_ferr, a_oerr, a_clr = 1'b0;

  logic       b_rxd = 1'b1, b_txd, b_tx_valid = 1'b0, b_tx_ready, b_rx_valid, b_rx_ready = 1'b0;
  logic [7:0] b_tx_data = '0, b_rx_data;
  logic [4:0] b_rx_count;
  logic       b_perr, b_ferr, b_oerr, b_clr = 1'b0;

  logic       c_txd, c_tx_valid = 1'b0, c_tx_ready, c_rx_valid, c_rx_ready = 1'b0;
  logic [8:0] c_tx_data = '0, c_rx_data;
  logic [4:0] c_rx_count;
  logic       c_perr, c_ferr, c_oerr, c_clr = 1'b0;

  uart_buffered_core #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATAWIDTH(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .rxd(a_rxd), .txd(a_txd), .tx_data(a_tx_data),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_ready(a_rx_ready), .rx_count(a_rx_count), .parity_err(a_perr), .frame_err(a_ferr),
    .overrun_err(a_oerr), .err_clr(a_clr));

  uart_buffered_core #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATAWIDTH(8), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .rxd(b_rxd), .txd(b_txd), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .rx_count(b_rx_count), .parity_err(b_perr), .frame_err(b_ferr),
    .overrun_err(b_oerr), .err_clr(b_clr));

  uart_buffered_core #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATAWIDTH(9), .PARITY(1),
                       .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .rxd(c_txd), .txd(c_txd), .tx_data(c_tx_data),
    .tx_valid(c_tx_valid), .tx_ready(c_tx_ready), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
    .rx_ready(c_rx_ready), .rx_count(c_rx_count), .parity_err(c_perr), .frame_err(c_ferr),
    .overrun_err(c_oerr), .err_clr(c_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame from the line rules: start 0, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int dw, input int par,
                                             input int stops, input bit bad_par,
                                             input bit bad_stop, output int n);
    logic [15:0] f;
    int ones;
    int k;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < dw; i++) begin
      f[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (par != 0) begin
      f[k] = ((par == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ bad_par;
      k++;
    end
    for (int s = 0; s < stops; s++) begin
      f[k] = !(s == 0 && bad_stop);
      k++;
    end
    n = k;
    return f;
  endfunction

  task automatic drive_rx(input int inst, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (inst == 0) a_rxd = f[i];
      else b_rxd = f[i];
      step(10);
    end
    a_rxd = 1'b1;
    b_rxd = 1'b1;
  endtask

  task automatic send_rx(input int inst, input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [15:0] f;
    int n;
    f = frame_bits({1'b0, d}, 8, (inst == 0) ? 0 : 2, 1, bad_par, bad_stop, n);
    drive_rx(inst, f, n);
  endtask

  task automatic pop_chk(input int inst, input logic [8:0] exp);
    case (inst)
      0: begin
        chk("a_pop_valid", 32'(a_rx_valid), 32'd1);
        chk("a_pop_data", 32'(a_rx_data), 32'(exp));
        a_rx_ready = 1'b1;
      end
      1: begin
        chk("b_pop_valid", 32'(b_rx_valid), 32'd1);
        chk("b_pop_data", 32'(b_rx_data), 32'(exp));
        b_rx_ready = 1'b1;
      end
      default: begin
        chk("c_pop_valid", 32'(c_rx_valid), 32'd1);
        chk("c_pop_data", 32'(c_rx_data), 32'(exp));
        c_rx_ready = 1'b1;
      end
    endcase
    step(1);
    a_rx_ready = 1'b0;
    b_rx_ready = 1'b0;
    c_rx_ready = 1'b0;
  endtask

  task automatic tx_frame_a(input logic [7:0] d);
    logic [15:0] f;
    int n;
    f = frame_bits({1'b0, d}, 8, 0, 1, 1'b0, 1'b0, n);
    a_tx_data = d;
    a_tx_valid = 1'b1;
    step(1);
    a_tx_valid = 1'b0;
    for (int c = 0; c < n * 10; c++) begin
      if (c == 37) a_tx_data = ~d;
      chk($sformatf("a_txd_c%0d", c), 32'(a_txd), 32'(f[c / 10]));
      chk("a_tx_ready_busy", 32'(a_tx_ready), 32'd0);
      step(1);
    end
    chk("a_tx_ready_done", 32'(a_tx_ready), 32'd1);
  endtask

  task automatic loop_c(input logic [8:0] v, input bit do_pop);
    int low;
    c_tx_data = v;
    c_tx_valid = 1'b1;
    step(1);
    c_tx_valid = 1'b0;
    low = 0;
    while (!c_tx_ready && low < 300) begin
      low++;
      step(1);
    end
    chk("c_tx_ready_low_cycles", 32'(low), 32'd130);
    if (do_pop) pop_chk(2, v);
  endtask

  logic [8:0] qa[$];
  logic [7:0] r;

  initial begin
    step(3);
    chk("rst_txd", 32'(a_txd), 32'd1);
    chk("rst_tx_ready", 32'(a_tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst_rx_count", 32'(a_rx_count), 32'd0);
    chk("rst_rx_data", 32'(a_rx_data), 32'd0);
    chk("rst_errs", 32'({a_perr, a_ferr, a_oerr}), 32'd0);
    rst_n = 1'b1;
    step(5);

    tx_frame_a(8'hA5);
    for (int i = 0; i < 2; i++) tx_frame_a(8'($urandom_range(0, 255)));

    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      send_rx(0, r, 1'b0, 1'b0);
      step(5);
      pop_chk(0, {1'b0, r});
    end

    send_rx(0, 8'h55, 1'b0, 1'b1);
    step(10);
    chk("a_frame_err", 32'(a_ferr), 32'd1);
    chk("a_frame_no_push", 32'(a_rx_count), 32'd0);
    chk("a_frame_no_perr", 32'(a_perr), 32'd0);
    send_rx(0, 8'h12, 1'b0, 1'b0);
    step(5);
    pop_chk(0, 9'h012);
    a_clr = 1'b1;
    step(1);
    a_clr = 1'b0;
    chk("a_frame_err_clr", 32'(a_ferr), 32'd0);

    a_rxd = 1'b0;
    step(3);
    a_rxd = 1'b1;
    step(40);
    chk("a_glitch_count", 32'(a_rx_count), 32'd0);
    chk("a_glitch_errs", 32'({a_perr, a_ferr, a_oerr}), 32'd0);
    r = 8'($urandom_range(0, 255));
    send_rx(0, r, 1'b0, 1'b0);
    step(5);
    pop_chk(0, {1'b0, r});

    for (int i = 0; i < 17; i++) begin
      send_rx(0, 8'(i), 1'b0, 1'b0);
      if (i < 16) qa.push_back(9'(i));
    end
    step(10);
    chk("a_full_count", 32'(a_rx_count), 32'd16);
    chk("a_overrun", 32'(a_oerr), 32'd1);
    while (qa.size() > 0) pop_chk(0, qa.pop_front());
    chk("a_drained", 32'(a_rx_count), 32'd0);
    a_clr = 1'b1;
    step(1);
    a_clr = 1'b0;
    chk("a_overrun_clr", 32'(a_oerr), 32'd0);

    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom_range(0, 255));
      send_rx(0, r, 1'b0, 1'b0);
      qa.push_back({1'b0, r});
    end
    step(10);
    chk("a_refill_count", 32'(a_rx_count), 32'd16);
    r = 8'($urandom_range(0, 255));
    // Push lands on the 99th edge after the start bit begins; pop on exactly that edge.
    fork
      send_rx(0, r, 1'b0, 1'b0);
      begin
        repeat (98) @(posedge clk);
        #1 a_rx_ready = 1'b1;
        @(posedge clk);
        #1 a_rx_ready = 1'b0;
      end
    join
    void'(qa.pop_front());
    qa.push_back({1'b0, r});
    step(5);
    chk("a_pushpop_count", 32'(a_rx_count), 32'd16);
    chk("a_pushpop_no_overrun", 32'(a_oerr), 32'd0);
    while (qa.size() > 0) pop_chk(0, qa.pop_front());

    send_rx(1, 8'h3C, 1'b0, 1'b0);
    step(5);
    chk("b_count_one", 32'(b_rx_count), 32'd1);
    chk("b_no_perr", 32'(b_perr), 32'd0);
    pop_chk(1, 9'h03C);
    send_rx(1, 8'h3C, 1'b1, 1'b0);
    step(5);
    chk("b_perr", 32'(b_perr), 32'd1);
    chk("b_perr_count", 32'(b_rx_count), 32'd0);
    chk("b_perr_no_ferr", 32'(b_ferr), 32'd0);
    b_clr = 1'b1;
    step(1);
    b_clr = 1'b0;
    chk("b_perr_clr", 32'(b_perr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      send_rx(1, r, 1'b0, 1'b0);
      step(5);
      pop_chk(1, {1'b0, r});
    end

    loop_c(9'h000, 1'b1);
    loop_c(9'h1FF, 1'b1);
    loop_c(9'h0AA, 1'b1);
    for (int i = 0; i < 2; i++) loop_c(9'($urandom_range(0, 511)), 1'b1);
    chk("c_no_errs", 32'({c_perr, c_ferr, c_oerr}), 32'd0);

    loop_c(9'h0F3, 1'b0);
    chk("c_held_count", 32'(c_rx_count), 32'd1);
    c_tx_data = 9'h155;
    c_tx_valid = 1'b1;
    step(1);
    c_tx_valid = 1'b0;
    step(40);
    rst_n = 1'b0;
    #1;
    chk("c_rst_txd", 32'(c_txd), 32'd1);
    chk("c_rst_count", 32'(c_rx_count), 32'd0);
    chk("c_rst_tx_ready", 32'(c_tx_ready), 32'd1);
    step(3);
    rst_n = 1'b1;
    step(200);
    chk("c_post_rst_errs", 32'({c_perr, c_ferr, c_oerr}), 32'd0);
    chk("c_post_rst_count", 32'(c_rx_count), 32'd0);
    chk("c_post_rst_valid", 32'(c_rx_valid), 32'd0);
    chk("c_post_rst_txd", 32'(c_txd), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
